dip_frame_ctrl: RTL

- Frame-level sequencer in front of the 3x3-window Sobel/erode/dilate pipeline.
- Gates the camera pixel stream into frames on vsync, and counts columns/rows.
- Latches mode/threshold configuration only at frame boundaries.
- After the last pixel, injects flush pixels so the row-delayed 3x3 window emits the final row, then pulses frame_done.

---
 rtl/dip_pkg.sv | 22 ++
 rtl/dip_pix_counter.sv | 43 ++++
 rtl/dip_frame_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dip_pkg.sv
// Shared encodings for the DIP front end: window-pipeline modes, frame
// sequencer states and the power-on Sobel threshold.
package dip_pkg;

    typedef enum logic [1:0] {
        DIP_BYPASS = 2'd0,
        DIP_SOBEL  = 2'd1,
        DIP_ERODE  = 2'd2,
        DIP_DILATE = 2'd3
    } dip_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        ACTIVE = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } dip_state_t;

    localparam logic [7:0] DIP_THR_DEFAULT = 8'd12;

endpackage

// File: rtl/dip_pix_counter.sv
// Raster column/row counter with wrap and clear. The last-pixel flag describes
// the pixel about to be counted, so a clear in the same cycle is honoured.
module dip_pix_counter #(
    parameter logic [15:0] COL_MAX = 16'd1023,
    parameter logic [15:0] ROW_MAX = 16'd767
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] cur_col;
    logic [15:0] cur_row;

    assign cur_col = clr ? 16'd0 : col;
    assign cur_row = clr ? 16'd0 : row;
    assign last    = (cur_col == COL_MAX) && (cur_row == ROW_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= 16'd0;
            row <= 16'd0;
        end else if (inc) begin
            if (cur_col == COL_MAX) begin
                col <= 16'd0;
                row <= (cur_row == ROW_MAX) ? 16'd0 : cur_row + 16'd1;
            end else begin
                col <= cur_col + 16'd1;
                row <= cur_row;
            end
        end else if (clr) begin
            col <= 16'd0;
            row <= 16'd0;
        end
    end

endmodule

// File: rtl/dip_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 window pipeline: gates pixels into frames,
// latches configuration at frame start and flushes the row delay at frame end.
module dip_frame_ctrl
    import dip_pkg::*;
#(
    parameter logic [15:0] CNT_COL_MAX = 16'd1023,
    parameter logic [15:0] CNT_ROW_MAX = 16'd767,
    parameter logic [7:0]  THR         = DIP_THR_DEFAULT,
    parameter logic [15:0] FLUSH_LEN   = CNT_COL_MAX + 16'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic       cam_vsync,
    input  logic       cam_en,
    input  logic [7:0] cam_data,
    input  logic       cfg_valid,
    input  logic [1:0] cfg_mode,
    input  logic [7:0] cfg_thr,
    output logic       dip_en,
    output logic [7:0] dip_data,
    output logic [1:0] mode,
    output logic [7:0] thr,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       err_pulse
);

    dip_state_t  state, state_nxt;
    dip_mode_t   sh_mode;
    logic [7:0]  sh_thr;
    logic [15:0] flush_cnt, flush_cnt_nxt;

    logic       dip_en_nxt, frame_done_nxt, err_nxt;
    logic [7:0] dip_data_nxt, thr_nxt;
    logic [1:0] mode_nxt;

    logic       cnt_clr, cnt_inc, pix_last;
    logic [1:0] latch_mode;
    logic [7:0] latch_thr;

    // A cfg_valid coinciding with vsync must reach this frame, so bypass the shadow.
    assign latch_mode = cfg_valid ? cfg_mode : sh_mode;
    assign latch_thr  = cfg_valid ? cfg_thr  : sh_thr;

    // Restart applies before the coincident pixel, so that pixel counts as col 0, row 0.
    assign cnt_clr = cam_vsync && (state == ARM || state == ACTIVE);
    assign cnt_inc = cam_en && (state == ACTIVE);

    dip_pix_counter #(
        .COL_MAX (CNT_COL_MAX),
        .ROW_MAX (CNT_ROW_MAX)
    ) u_pix_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (pix_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode <= DIP_BYPASS;
            sh_thr  <= THR;
        end else if (cfg_valid) begin
            sh_mode <= dip_mode_t'(cfg_mode);
            sh_thr  <= cfg_thr;
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        dip_en_nxt     = 1'b0;
        dip_data_nxt   = 8'd0;
        mode_nxt       = mode;
        thr_nxt        = thr;
        frame_done_nxt = 1'b0;
        err_nxt        = 1'b0;

        unique case (state)
            IDLE: begin
                if (ctrl_en) state_nxt = ARM;
            end
            ARM: begin
                if (cam_vsync) begin
                    mode_nxt  = latch_mode;
                    thr_nxt   = latch_thr;
                    state_nxt = ACTIVE;
                end else if (!ctrl_en) begin
                    state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (cam_vsync) begin
                    err_nxt  = 1'b1;
                    mode_nxt = latch_mode;
                    thr_nxt  = latch_thr;
                end
                if (cam_en) begin
                    dip_en_nxt   = 1'b1;
                    dip_data_nxt = cam_data;
                    if (pix_last) begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = 16'd0;
                    end
                end
            end
            FLUSH: begin
                dip_en_nxt = 1'b1;
                err_nxt    = cam_en || cam_vsync;
                if (flush_cnt == FLUSH_LEN - 16'd1) begin
                    state_nxt     = DONE;
                    flush_cnt_nxt = 16'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt + 16'd1;
                end
            end
            DONE: begin
                frame_done_nxt = 1'b1;
                state_nxt      = ctrl_en ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= 16'd0;
            dip_en     <= 1'b0;
            dip_data   <= 8'd0;
            mode       <= DIP_BYPASS;
            thr        <= THR;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            dip_en     <= dip_en_nxt;
            dip_data   <= dip_data_nxt;
            mode       <= mode_nxt;
            thr        <= thr_nxt;
            frame_busy <= (state_nxt == ACTIVE) || (state_nxt == FLUSH);
            frame_done <= frame_done_nxt;
            err_pulse  <= err_nxt;
        end
    end

endmodule
